// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : univ_shift_reg_if                                               |
// | Purpose  : Control/data bundle for the universal shift register.           |
// |            master = driver of controls and data, observer of q decodes.    |
// |            slave  = the register itself.                                   |
// | Signals  : clr, en, mode[1:0], d[WIDTH-1:0], sr_in, sl_in  (to register)   |
// |            q[WIDTH-1:0], so_r, so_l, zero                 (from register)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface univ_shift_reg_if #(
  parameter int WIDTH = 4
) ();
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sr_in;
  logic             sl_in;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic             zero;

  modport master (
    output clr, en, mode, d, sr_in, sl_in,
    input  q, so_r, so_l, zero
  );

  modport slave (
    input  clr, en, mode, d, sr_in, sl_in,
    output q, so_r, so_l, zero
  );
endinterface
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : univ_shift_reg                                                  |
// | Purpose  : WIDTH-bit universal shift register: hold, shift right, shift    |
// |            left, parallel load, optional rotate, synchronous clear.        |
// | Ports    : clk      rising-edge clock                                      |
// |            reset_n  asynchronous active-low reset, q <= RESET_VAL          |
// |            bus      univ_shift_reg_if.slave (clr, en, mode, d, sr_in,      |
// |                     sl_in in; q, so_r, so_l, zero out)                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module univ_shift_reg #(
  parameter int          WIDTH     = 4,
  parameter logic [63:0] RESET_VAL = 64'd0,
  parameter bit          ROTATE    = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  univ_shift_reg_if.slave  bus
);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("univ_shift_reg: WIDTH must be in 2..64");
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_reset_val = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_sr_bit;   // bit entering the MSB on a right shift
  logic             w_sl_bit;   // bit entering the LSB on a left shift

  // In rotate mode the serial inputs are not referenced at all, so an
  // undriven or X serial input can never reach q.
  generate
    if (ROTATE) begin : g_rotate
      assign w_sr_bit = r_q[0];
      assign w_sl_bit = r_q[WIDTH-1];
    end else begin : g_serial
      assign w_sr_bit = bus.sr_in;
      assign w_sl_bit = bus.sl_in;
    end
  endgenerate

  // clr outranks en, and en outranks mode.
  always_comb begin
    w_next = r_q;
    if (bus.clr) begin
      w_next = '0;
    end else if (bus.en) begin
      case (bus.mode)
        2'b01:   w_next = {w_sr_bit, r_q[WIDTH-1:1]};
        2'b10:   w_next = {r_q[WIDTH-2:0], w_sl_bit};
        2'b11:   w_next = bus.d;
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= c_reset_val;
    end else begin
      r_q <= w_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.so_r = r_q[0];
  assign bus.so_l = r_q[WIDTH-1];
  assign bus.zero = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_univ_shift_reg                                               |
// | Purpose  : Self-checking bench for univ_shift_reg. Three instances:        |
// |            u0 WIDTH=4 serial, u1 WIDTH=4 rotate, u2 WIDTH=8 RESET_VAL=A5.  |
// |            Directed scenarios followed by random stimulus, all checked     |
// |            against an arithmetic reference model.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_univ_shift_reg;

  logic clk;
  logic reset_n;

  univ_shift_reg_if #(.WIDTH(4)) if0 ();
  univ_shift_reg_if #(.WIDTH(4)) if1 ();
  univ_shift_reg_if #(.WIDTH(8)) if2 ();

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(64'd0), .ROTATE(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  univ_shift_reg #(.WIDTH(4), .RESET_VAL(64'd0), .ROTATE(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(64'hA5), .ROTATE(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m0, m1, m2;   // reference contents of u0, u1, u2

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Next register value from the behavioural rules, using plain arithmetic.
  function automatic logic [63:0] model_next(input int w, input bit rot, input logic [63:0] cur,
                                             input logic c, input logic e, input logic [1:0] m,
                                             input logic [63:0] dv, input logic sr, input logic sl);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (c === 1'b1) return 64'd0;
    if (e !== 1'b1) return cur;
    case (m)
      2'd1: return rot ? ((cur >> 1) | ((cur & 64'd1) << (w - 1)))
                       : ((cur >> 1) | (64'(sr) << (w - 1)));
      2'd2: return rot ? (((cur << 1) & mask) | ((cur >> (w - 1)) & 64'd1))
                       : (((cur << 1) | 64'(sl)) & mask);
      2'd3: return dv & mask;
      default: return cur;
    endcase
  endfunction

  task automatic compare_all();
    check_val("u0_q",    64'(if0.q),    m0);
    check_val("u0_so_r", 64'(if0.so_r), m0 & 64'd1);
    check_val("u0_so_l", 64'(if0.so_l), (m0 >> 3) & 64'd1);
    check_val("u0_zero", 64'(if0.zero), 64'(m0 == 64'd0));
    check_val("u1_q",    64'(if1.q),    m1);
    check_val("u1_noX",  64'($isunknown(if1.q)), 64'd0);
    check_val("u1_so_r", 64'(if1.so_r), m1 & 64'd1);
    check_val("u1_so_l", 64'(if1.so_l), (m1 >> 3) & 64'd1);
    check_val("u2_q",    64'(if2.q),    m2);
    check_val("u2_so_r", 64'(if2.so_r), m2 & 64'd1);
    check_val("u2_so_l", 64'(if2.so_l), (m2 >> 7) & 64'd1);
    check_val("u2_zero", 64'(if2.zero), 64'(m2 == 64'd0));
  endtask

  // One rising edge: advance the model with the inputs sampled at the edge,
  // then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      m0 = model_next(4, 1'b0, m0, if0.clr, if0.en, if0.mode, 64'(if0.d), if0.sr_in, if0.sl_in);
      m1 = model_next(4, 1'b1, m1, if1.clr, if1.en, if1.mode, 64'(if1.d), if1.sr_in, if1.sl_in);
      m2 = model_next(8, 1'b0, m2, if2.clr, if2.en, if2.mode, 64'(if2.d), if2.sr_in, if2.sl_in);
    end
    #1;
    compare_all();
  endtask

  // Same controls to every instance; u1 always sees X on its serial inputs.
  task automatic drive(input logic c, input logic e, input logic [1:0] m,
                       input logic [7:0] dv, input logic sr, input logic sl);
    if0.clr = c; if0.en = e; if0.mode = m; if0.d = dv[3:0]; if0.sr_in = sr;   if0.sl_in = sl;
    if1.clr = c; if1.en = e; if1.mode = m; if1.d = dv[3:0]; if1.sr_in = 1'bx; if1.sl_in = 1'bx;
    if2.clr = c; if2.en = e; if2.mode = m; if2.d = dv;      if2.sr_in = sr;   if2.sl_in = sl;
  endtask

  task automatic async_reset_pulse();
    #2;
    reset_n = 1'b0;
    m0 = 64'd0; m1 = 64'd0; m2 = 64'hA5;
    #1;
    compare_all();
    #2;
    reset_n = 1'b1;
  endtask

  task automatic rand_drive();
    if0.clr = ($urandom_range(0, 7) == 0); if0.en = ($urandom_range(0, 7) != 0);
    if0.mode = 2'($urandom); if0.d = 4'($urandom);
    if0.sr_in = 1'($urandom); if0.sl_in = 1'($urandom);
    if1.clr = ($urandom_range(0, 7) == 0); if1.en = ($urandom_range(0, 7) != 0);
    if1.mode = 2'($urandom); if1.d = 4'($urandom);
    if1.sr_in = $urandom_range(0, 1) ? 1'bx : 1'($urandom);
    if1.sl_in = $urandom_range(0, 1) ? 1'bx : 1'($urandom);
    if2.clr = ($urandom_range(0, 7) == 0); if2.en = ($urandom_range(0, 7) != 0);
    if2.mode = 2'($urandom); if2.d = 8'($urandom);
    if2.sr_in = 1'($urandom); if2.sl_in = 1'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    m0 = 64'd0; m1 = 64'd0; m2 = 64'hA5;
    #12;
    compare_all();
    check_val("rst_u2_q", 64'(if2.q), 64'hA5);
    #3;
    reset_n = 1'b1;

    // Load 1011 then shift right twice with sr_in=1.
    drive(1'b0, 1'b1, 2'b11, 8'h0B, 1'b0, 1'b0);
    tick();
    check_val("load_q", 64'(if0.q), 64'hB);
    drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
    tick();
    check_val("shr1_q", 64'(if0.q), 64'hD);
    check_val("shr1_so_r", 64'(if0.so_r), 64'd1);
    tick();
    check_val("shr2_q", 64'(if0.q), 64'hE);
    check_val("shr2_so_r", 64'(if0.so_r), 64'd0);

    // Load 1011 then shift left four times with sl_in=0.
    drive(1'b0, 1'b1, 2'b11, 8'h0B, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    tick(); check_val("shl1_q", 64'(if0.q), 64'h6);
    tick(); check_val("shl2_q", 64'(if0.q), 64'hC);
    tick(); check_val("shl3_q", 64'(if0.q), 64'h8);
    check_val("shl3_zero", 64'(if0.zero), 64'd0);
    tick(); check_val("shl4_q", 64'(if0.q), 64'h0);
    check_val("shl4_zero", 64'(if0.zero), 64'd1);

    // Rotate right on u1 from 1001, X on serial inputs.
    drive(1'b0, 1'b1, 2'b11, 8'h09, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    tick(); check_val("rot1_q", 64'(if1.q), 64'hC);
    tick(); check_val("rot2_q", 64'(if1.q), 64'h6);
    tick(); check_val("rot3_q", 64'(if1.q), 64'h3);
    tick(); check_val("rot4_q", 64'(if1.q), 64'h9);

    // Priority: clr beats en low and load; then en low holds.
    drive(1'b0, 1'b1, 2'b11, 8'h05, 1'b0, 1'b0);
    tick();
    check_val("pri_load_q", 64'(if0.q), 64'h5);
    drive(1'b1, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0);
    tick(); check_val("pri_clr_q", 64'(if0.q), 64'h0);
    drive(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0);
    tick(); check_val("pri_hold_q", 64'(if0.q), 64'h0);

    // Asynchronous reset mid-cycle with q=1011.
    drive(1'b0, 1'b1, 2'b11, 8'h0B, 1'b0, 1'b0);
    tick();
    check_val("pre_rst_q", 64'(if0.q), 64'hB);
    async_reset_pulse();
    check_val("async_rst_u2_q", 64'(if2.q), 64'hA5);

    // u2: load 80 then shift right seven times with sr_in=0.
    drive(1'b0, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check_val("w8_shr7_q", 64'(if2.q), 64'h01);
    check_val("w8_shr7_so_r", 64'(if2.so_r), 64'd1);

    // Random phase with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      rand_drive();
      tick();
      if ((i % 64) == 63) async_reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
